// File: rtl/fmap_stream_buffer.sv
// Feature-map stream buffer: captures one D x D x C map of raw words from a
// producer stream, then replays it on request with consumer back-pressure.
module fmap_stream_buffer #(
  parameter int data_width = 32,
  parameter int D          = 35,
  parameter int C          = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [data_width-1:0] pxl_in,
  input  logic                  start,
  input  logic                  hold,
  output logic [data_width-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  busy,
  output logic                  overflow
);

  localparam int N  = D * D * C;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [AW-1:0]           wr_cnt_r;
  logic [AW-1:0]           rd_cnt_r;
  logic [data_width-1:0]   mem_r [0:N-1];
  logic                    wr_en_s;
  logic                    rd_en_s;
  logic                    ovf_set_s;
  logic [data_width-1:0]   pxl_out_r;
  logic                    valid_out_r;
  logic                    full_r;
  logic                    busy_r;
  logic                    overflow_r;

  // Next-state decode plus write/read enables and overflow detection.
  always_comb begin
    state_s   = state_r;
    wr_en_s   = 1'b0;
    rd_en_s   = 1'b0;
    ovf_set_s = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (valid_in) begin
          wr_en_s = 1'b1;
          if (wr_cnt_r == LAST_ADDR) begin
            state_s = ST_FULL;
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_FULL: begin
        ovf_set_s = valid_in;
        if (start) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_FULL;
        end
      end
      ST_DRAIN: begin
        ovf_set_s = valid_in;
        if (!hold) begin
          rd_en_s = 1'b1;
          if (rd_cnt_r == LAST_ADDR) begin
            state_s = ST_FILL;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          rd_en_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_FILL;
      end
    endcase
  end

  // State, counters, status flags and the read/output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_FILL;
      wr_cnt_r    <= {AW{1'b0}};
      rd_cnt_r    <= {AW{1'b0}};
      pxl_out_r   <= {data_width{1'b0}};
      valid_out_r <= 1'b0;
      full_r      <= 1'b0;
      busy_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      full_r      <= (state_s == ST_FULL);
      busy_r      <= (state_s == ST_DRAIN);
      valid_out_r <= rd_en_s;
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
      if (wr_en_s) begin
        wr_cnt_r <= (wr_cnt_r == LAST_ADDR) ? {AW{1'b0}} : wr_cnt_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_cnt_r  <= (rd_cnt_r == LAST_ADDR) ? {AW{1'b0}} : rd_cnt_r + AW'(1);
        pxl_out_r <= mem_r[rd_cnt_r];
      end else if ((state_r == ST_FULL) && start) begin
        rd_cnt_r <= {AW{1'b0}};
      end
    end
  end

  // Map storage; deliberately not cleared by reset, the next fill overwrites it.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_cnt_r] <= pxl_in;
    end
  end

  assign pxl_out   = pxl_out_r;
  assign valid_out = valid_out_r;
  assign full      = full_r;
  assign busy      = busy_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_fmap_stream_buffer.sv
// Scoreboard bench for fmap_stream_buffer with a small 3x3x2 map: stimulus
// queues expected replay words, a forked monitor pops them on valid_out.
module tb_fmap_stream_buffer;

  localparam int D = 3;
  localparam int C = 2;
  localparam int N = D * D * C;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pxl_in;
  logic        start;
  logic        hold;
  logic [31:0] pxl_out;
  logic        valid_out;
  logic        full;
  logic        busy;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;
  int          mon_valid = 0;
  logic [31:0] exp_q [$];

  fmap_stream_buffer #(.data_width(32), .D(D), .C(C)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .start(start), .hold(hold), .pxl_out(pxl_out), .valid_out(valid_out),
    .full(full), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && valid_out) begin
        mon_valid++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got %h expected no output at %0t", pxl_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("replay_word", pxl_out, e);
        end
      end
    end
  endtask

  task automatic fill(input logic [31:0] base, input int first, input int count, input bit gapped);
    for (int i = first; i < first + count; i++) begin
      valid_in = 1'b1;
      pxl_in   = base + 32'(i);
      tick();
      chk((i == N - 1) ? "full_set" : "full_early", 32'(full), (i == N - 1) ? 32'd1 : 32'd0);
      if (gapped) begin
        valid_in = 1'b0;
        pxl_in   = 32'hDEAD_BEEF;
        tick();
        chk("full_gap", 32'(full), (i == N - 1) ? 32'd1 : 32'd0);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic replay(input logic [31:0] base, input int hold_after, input bit b2b);
    int cyc;
    int vstart;
    for (int i = 0; i < N; i++) exp_q.push_back(base + 32'(i));
    vstart = mon_valid;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on", 32'(busy), 32'd1);
    chk("full_off", 32'(full), 32'd0);
    cyc = 0;
    if (hold_after >= 0) begin
      repeat (hold_after + 1) tick();
      cyc += hold_after + 1;
      chk("pre_hold_valid", 32'(valid_out), 32'd1);
      chk("pre_hold_word", pxl_out, base + 32'(hold_after));
      hold = 1'b1;
      repeat (3) begin
        tick();
        cyc++;
        chk("hold_valid", 32'(valid_out), 32'd0);
        chk("hold_word", pxl_out, base + 32'(hold_after));
      end
      hold = 1'b0;
    end
    while (busy && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("drain_cycles", 32'(cyc), 32'(N + ((hold_after >= 0) ? 3 : 0)));
    if (!b2b) begin
      tick();
      chk("valid_fall", 32'(valid_out), 32'd0);
      chk("busy_off", 32'(busy), 32'd0);
      chk("full_after", 32'(full), 32'd0);
      chk("valid_count", 32'(mon_valid - vstart), 32'(N));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    pxl_in   = 32'h0;
    start    = 1'b0;
    hold     = 1'b0;
    fork
      monitor();
    join_none
    repeat (2) tick();
    chk("rst_pxl_out", pxl_out, 32'h0);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick();

    // Basic fill and replay
    fill(32'h3F80_0000, 0, N, 1'b0);
    replay(32'h3F80_0000, -1, 1'b0);

    // Gapped write
    fill(32'h3F80_0000, 0, N, 1'b1);
    replay(32'h3F80_0000, -1, 1'b0);

    // Back-pressure after word 5
    fill(32'h4100_0000, 0, N, 1'b0);
    replay(32'h4100_0000, 5, 1'b0);

    // Ignored start in FILL, overflow after full
    fill(32'h4200_0000, 0, 10, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_fill_busy", 32'(busy), 32'd0);
    tick();
    chk("start_in_fill_valid", 32'(valid_out), 32'd0);
    fill(32'h4200_0000, 10, N - 10, 1'b0);
    valid_in = 1'b1;
    pxl_in   = 32'hFFFF_FFFF;
    repeat (2) tick();
    valid_in = 1'b0;
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("full_kept", 32'(full), 32'd1);
    replay(32'h4200_0000, -1, 1'b0);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("overflow_cleared", 32'(overflow), 32'd0);

    // Reset in the middle of a replay
    fill(32'h4300_0000, 0, N, 1'b0);
    for (int i = 0; i < N; i++) exp_q.push_back(32'h4300_0000 + 32'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("mid_word7", pxl_out, 32'h4300_0007);
    reset = 1'b1;
    tick();
    exp_q.delete();
    chk("mid_rst_valid", 32'(valid_out), 32'd0);
    chk("mid_rst_pxl", pxl_out, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    fill(32'h4400_0000, 0, N, 1'b0);
    replay(32'h4400_0000, -1, 1'b0);

    // Back-to-back maps
    fill(32'h4500_0000, 0, N, 1'b0);
    replay(32'h4500_0000, -1, 1'b1);
    fill(32'h4600_0000, 0, N, 1'b0);
    replay(32'h4600_0000, -1, 1'b0);

    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_stream_buffer.md
# fmap_stream_buffer

Stream-side feature-map buffer between Inception-style stages. Sinks the `valid_out`/`pxl_out` stream of a producer stage, stores one complete feature map (D×D pixels × C channels of 32-bit IEEE-754 words) in a single-port-per-side RAM, and replays it on command as a `valid_in`/`pxl_in`-compatible stream for the next stage. This replaces the file-based capture and replay used in simulation between stages, so stages can be chained in hardware.

## Interface
- `data_width`, 32, pixel word width (IEEE-754 single, passed through untouched)
- `D`, 35, feature-map side length
- `C`, 1, channels per map
- `N` (localparam), D*D*C, words per map; `AW` = $clog2(N)
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `valid_in`  in  1  write strobe from the producer stage
- `pxl_in`  in  data_width  producer pixel
- `start`  in  1  replay request, sampled only in FULL
- `hold`  in  1  consumer back-pressure during DRAIN
- `pxl_out`  out  data_width  replayed pixel, registered
- `valid_out`  out  1  replay strobe, registered
- `full`  out  1  map complete, awaiting `start`
- `busy`  out  1  high in DRAIN
- `overflow`  out  1  sticky error flag

## Operation
- States: FILL (reset state), FULL, DRAIN.
- FILL: each cycle with `valid_in`=1 writes `pxl_in` to `mem[wr_cnt]` and increments `wr_cnt`. Gaps in `valid_in` are allowed and do not change state. On the write to address N-1, go to FULL and clear `wr_cnt` to 0.
- FULL: `full`=1. `valid_in` is ignored and sets `overflow`. `start`=1 goes to DRAIN with `rd_cnt`=0.
- DRAIN: `busy`=1. Each cycle with `hold`=0:
  - `pxl_out` <= `mem[rd_cnt]`, `valid_out` <= 1, `rd_cnt` increments.
  - On the read of address N-1, go to FILL and clear `rd_cnt`.
- DRAIN with `hold`=1: `valid_out` <= 0, `pxl_out` holds its value, `rd_cnt` does not advance.
- `valid_in` during DRAIN is ignored and sets `overflow`.
- `start` outside FULL is ignored. `start` is level-sampled, so holding it high after entering DRAIN has no further effect.
- `overflow` clears only on `reset`.
- Words pass through bit-exact. There is no arithmetic on pixel data.
- Counters are AW bits wide and are compared against N-1, never against 2^AW-1. No wrap-around past N-1.
- Reset mid-operation:
  - State returns to FILL; `wr_cnt`, `rd_cnt`, `pxl_out`, `valid_out`, `full`, `busy` and `overflow` all go to 0.
  - RAM contents are not cleared. The next fill overwrites them.

## Timing
- Reset values: `pxl_out`=0, `valid_out`=0, `full`=0, `busy`=0, `overflow`=0.
- Write latency: the word sampled at edge k is in RAM after edge k. The N-th write at edge k gives `full`=1 after edge k.
- Replay latency:
  - `start` sampled at edge k → `busy`=1 after edge k.
  - First `valid_out`=1 with `pxl_out`=`mem[0]` after edge k+1.
- With `hold`=0 throughout, replay is exactly N consecutive `valid_out` cycles.
- `valid_out` falls at the edge after the last word. `busy` and the return to FILL take effect on the same edge that presents `mem[N-1]`.
- A new `valid_in` is accepted as write 0 on the first cycle after that edge. A producer may stream the next map back-to-back with the end of replay.
- RAM has a synchronous read. The output register is the read register, so there is no extra pipeline stage.

## Test plan
- **Basic fill and replay** (D=3, C=2, N=18): reset, then stream 18 words 0x3F800000+i (i=0..17) with `valid_in` continuous.
  - `full`=1 after the 18th edge.
  - `start` one cycle → 18 consecutive `valid_out` cycles beginning one edge after `start`, `pxl_out`=0x3F800000+i in order.
  - `busy`=0, `full`=0 afterwards.
- **Gapped write**: same 18 words with `valid_in` toggling every other cycle → identical replay. `full` rises only after the 18th accepted word.
- **Back-pressure**: during replay, assert `hold` for 3 cycles after word 5.
  - `valid_out`=0 for those 3 cycles; `pxl_out` stays at word 5.
  - Words 6..17 then follow with no loss or duplication; total valid count is 18.
- **Overflow and ignored start**:
  - `start` while FILL (10 words in) → no replay.
  - After `full`, 2 extra `valid_in` → `overflow`=1 and RAM unchanged; replay still shows words 0..17.
  - `overflow` stays 1 until `reset`.
- **Reset mid-DRAIN**: `reset` after word 7 is output.
  - Next cycle: `valid_out`=0, `pxl_out`=0, `busy`=0, `full`=0, `overflow`=0.
  - A fresh fill of 18 new words then replays the new data only.
- **Back-to-back maps**: start a second 18-word stream on the cycle after the last replay edge.
  - All 18 words are accepted, `full` reasserts, and the second replay is correct.
